// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller and the PC mux it steers.
// Holds the FSM state encoding, the pc_sel codes and the redirect priority.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_KILL = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

    // Redirect target priority: jump-register beats jump beats taken branch.
    function automatic logic [1:0] redirect_sel(input logic z, input logic j, input logic jr);
        logic [1:0] sel;
        sel = SEL_SEQ;
        if (jr)
            sel = SEL_JR;
        else if (j)
            sel = SEL_J;
        else if (z)
            sel = SEL_BR;
        return sel;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
// Cleared by the synchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments and a reset sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: drives the instruction-memory request, steers the PC mux,
// squashes wrong-path fetches on redirects and declares a sticky fault on access timeout.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Z,
    input  logic             J,
    input  logic             JR,
    input  logic             stall,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [1:0]       pc_sel,
    output logic             PC_IFWrite,
    output logic             IFID_Write,
    output logic             IF_flush,
    output logic             fetch_valid,
    output logic             imem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    fetch_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;

    logic active;
    logic redirect;
    logic timeout_hit;

    // Combinational outputs are gated by reset so everything reads 0 while reset is held.
    assign active      = reset && ((state == ST_REQ) || (state == ST_KILL));
    assign redirect    = active && (Z || J || JR) && !stall;
    assign timeout_hit = active && !imem_ready && (wait_cnt == WAIT_LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_sel      = SEL_SEQ;
        PC_IFWrite  = 1'b0;
        IFID_Write  = 1'b0;
        IF_flush    = 1'b0;
        fetch_valid = 1'b0;
        if (redirect) begin
            pc_sel     = redirect_sel(Z, J, JR);
            PC_IFWrite = 1'b1;
            IFID_Write = 1'b1;
            IF_flush   = 1'b1;
        end else if (reset && (state == ST_REQ) && !stall && imem_ready) begin
            PC_IFWrite  = 1'b1;
            IFID_Write  = 1'b1;
            fetch_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            imem_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    wait_cnt <= '0;
                    imem_req <= 1'b1;
                end
                ST_REQ, ST_KILL: begin
                    if (imem_ready) begin
                        // A response completes the outstanding access; a pending kill is over.
                        wait_cnt <= '0;
                        state    <= ST_REQ;
                    end else if (timeout_hit) begin
                        state    <= ST_HALT;
                        imem_req <= 1'b0;
                        imem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (redirect)
                            state <= ST_KILL;
                    end
                end
                ST_HALT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (active && stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for single-cycle REQ behaviour plus
// hand sequences for kill, reset, stall, timeout and counter saturation.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset, z, j, jr, stall, ready;
    logic        imem_req, pw, iw, fl, fv, err;
    logic [1:0]  sel;
    logic [15:0] scnt, fcnt;

    logic        s_reset, s_z, s_j, s_jr, s_stall, s_ready;
    logic        s_imem_req, s_pw, s_iw, s_fl, s_fv, s_err;
    logic [1:0]  s_sel;
    logic [3:0]  s_scnt, s_fcnt;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       z, j, jr, stall, ready;
        logic [1:0] sel;
        logic       pw, iw, fl, fv;
        int         fcnt, scnt;
    } vec_t;

    vec_t tbl[8];

    fetch_ctrl u_dut (
        .clk(clk), .reset(reset), .Z(z), .J(j), .JR(jr), .stall(stall), .imem_ready(ready),
        .imem_req(imem_req), .pc_sel(sel), .PC_IFWrite(pw), .IFID_Write(iw), .IF_flush(fl),
        .fetch_valid(fv), .imem_err(err), .stall_cnt(scnt), .flush_cnt(fcnt)
    );

    fetch_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_small (
        .clk(clk), .reset(s_reset), .Z(s_z), .J(s_j), .JR(s_jr), .stall(s_stall), .imem_ready(s_ready),
        .imem_req(s_imem_req), .pc_sel(s_sel), .PC_IFWrite(s_pw), .IFID_Write(s_iw), .IF_flush(s_fl),
        .fetch_valid(s_fv), .imem_err(s_err), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic [1:0] e_sel, input logic e_pw,
                              input logic e_iw, input logic e_fl, input logic e_fv, input logic e_req);
        check({name, ".pc_sel"},      sel,      e_sel);
        check({name, ".PC_IFWrite"},  pw,       e_pw);
        check({name, ".IFID_Write"},  iw,       e_iw);
        check({name, ".IF_flush"},    fl,       e_fl);
        check({name, ".fetch_valid"}, fv,       e_fv);
        check({name, ".imem_req"},    imem_req, e_req);
    endtask

    task automatic drive(input logic dz, input logic dj, input logic djr, input logic dst, input logic drdy);
        z = dz; j = dj; jr = djr; stall = dst; ready = drdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // z, j, jr, stall, ready | sel, pw, iw, fl, fv | flush_cnt, stall_cnt seen this cycle
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1};

        reset = 1'b0; s_reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        s_z = 1'b0; s_j = 1'b0; s_jr = 1'b0; s_stall = 1'b0; s_ready = 1'b0;

        // Reset held with redirect and ready active: everything stays 0.
        repeat (2) next_cycle();
        @(negedge clk);
        check_outs("in_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("in_reset.imem_err", err, 0);
        check("in_reset.stall_cnt", scnt, 0);
        check("in_reset.flush_cnt", fcnt, 0);
        next_cycle();

        // First cycle after release is IDLE; the ready pulse there is ignored.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_outs("first_fetch", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].z, tbl[i].j, tbl[i].jr, tbl[i].stall, tbl[i].ready);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].sel, tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].fv, 1'b1);
            check($sformatf("vec%0d.flush_cnt", i), fcnt, tbl[i].fcnt);
            check($sformatf("vec%0d.stall_cnt", i), scnt, tbl[i].scnt);
            next_cycle();
        end

        // Branch with no response pending -> KILL; the late response is dropped.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("kill_enter", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_outs($sformatf("kill_wait%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        check("kill.flush_cnt", fcnt, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("kill_drop", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        @(negedge clk);
        check_outs("kill_resume", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle();

        // Redirects while in KILL load new targets; redirect plus ready leaves KILL.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("kill_redir_j", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("kill_redir_jr", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("kill_exit", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("kill_exit.flush_cnt", fcnt, 8);
        next_cycle();

        // Reset during an outstanding access abandons it.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("rst_mid_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.flush_cnt", fcnt, 0);
        next_cycle();

        // Stall for 5 cycles with a pending branch: nothing is redirected.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d.IF_flush", i), fl, 0);
            check($sformatf("stall%0d.PC_IFWrite", i), pw, 0);
            check($sformatf("stall%0d.fetch_valid", i), fv, 0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("stall.stall_cnt", scnt, 5);
        check("stall.flush_cnt", fcnt, 0);
        check("stall_release.fetch_valid", fv, 1);

        // Timeout on the small instance: TIMEOUT=4, no response ever arrives.
        next_cycle();
        s_reset = 1'b1;
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d.imem_req", i), s_imem_req, 1);
            check($sformatf("to_wait%0d.imem_err", i), s_err, 0);
            next_cycle();
        end
        @(negedge clk);
        check("to_halt.imem_err", s_err, 1);
        check("to_halt.imem_req", s_imem_req, 0);
        s_z = 1'b1; s_j = 1'b1;
        @(negedge clk);
        check("halt_redir.IF_flush", s_fl, 0);
        check("halt_redir.PC_IFWrite", s_pw, 0);
        next_cycle();
        @(negedge clk);
        check("halt_redir.flush_cnt", s_fcnt, 0);
        check("halt_redir.imem_err", s_err, 1);
        s_reset = 1'b0; s_z = 1'b0; s_j = 1'b0;
        next_cycle();
        check("halt_reset.imem_err", s_err, 0);

        // Saturation of the 4-bit stall counter.
        s_reset = 1'b1; s_ready = 1'b1;
        next_cycle();
        s_stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 14) check("sat14.stall_cnt", s_scnt, 14);
            if (i == 15) check("sat15.stall_cnt", s_scnt, 15);
            if (i == 16) check("sat16.stall_cnt", s_scnt, 15);
        end
        check("sat20.stall_cnt", s_scnt, 15);
        check("sat20.imem_err", s_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
